// File: rtl/dm_mm2s_arbiter.sv
// dm_mm2s_arbiter: shares one DataMover MM2S command/data/status channel set between two requesters
module dm_mm2s_arbiter #(
    parameter int MAX_OUT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s0_cmd_tvalid,
    output logic         s0_cmd_tready,
    input  logic [71:0]  s0_cmd_tdata,
    input  logic         s1_cmd_tvalid,
    output logic         s1_cmd_tready,
    input  logic [71:0]  s1_cmd_tdata,
    output logic         m_cmd_tvalid,
    input  logic         m_cmd_tready,
    output logic [71:0]  m_cmd_tdata,
    input  logic         s_data_tvalid,
    output logic         s_data_tready,
    input  logic [127:0] s_data_tdata,
    input  logic [15:0]  s_data_tkeep,
    input  logic         s_data_tlast,
    output logic         m0_data_tvalid,
    input  logic         m0_data_tready,
    output logic [127:0] m0_data_tdata,
    output logic [15:0]  m0_data_tkeep,
    output logic         m0_data_tlast,
    output logic         m1_data_tvalid,
    input  logic         m1_data_tready,
    output logic [127:0] m1_data_tdata,
    output logic [15:0]  m1_data_tkeep,
    output logic         m1_data_tlast,
    input  logic         s_sts_tvalid,
    output logic         s_sts_tready,
    input  logic [7:0]   s_sts_tdata,
    output logic         m0_sts_tvalid,
    input  logic         m0_sts_tready,
    output logic [7:0]   m0_sts_tdata,
    output logic         m1_sts_tvalid,
    input  logic         m1_sts_tready,
    output logic [7:0]   m1_sts_tdata,
    output logic [4:0]   outstanding,
    output logic         err_sticky
);
    localparam int AW = $clog2(MAX_OUT);
    localparam logic [4:0] LIM = 5'(MAX_OUT);

    typedef enum logic {ARB, SEND} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_prio;
    logic [71:0]   r_cmd;
    logic [4:0]    r_out;
    logic          r_err;
    logic          r_fifo [MAX_OUT];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_el0, w_el1, w_acc, w_g;
    logic [71:0]   w_cmd_sel;
    logic          w_empty, w_head, w_pop;
    logic          w_tag, w_bad, w_sts_hs, w_dec, w_err_set, w_unused;

    assign w_el0     = s0_cmd_tvalid & (r_out < LIM);
    assign w_el1     = s1_cmd_tvalid & (r_out < LIM);
    assign w_cmd_sel = w_g ? s1_cmd_tdata : s0_cmd_tdata;

    // Round-robin grant in ARB; SEND holds until the DataMover takes the command
    always_comb begin
        w_g         = (w_el0 & w_el1) ? r_prio : w_el1;
        w_acc       = (r_state == ARB) & (w_el0 | w_el1);
        w_state_nxt = (r_state == ARB) ? (w_acc ? SEND : ARB) : (m_cmd_tready ? ARB : SEND);
    end

    assign s0_cmd_tready = w_acc & ~w_g;
    assign s1_cmd_tready = w_acc & w_g;
    assign m_cmd_tvalid  = (r_state == SEND);
    assign m_cmd_tdata   = r_cmd;

    assign w_empty        = (r_cnt == '0);
    assign w_head         = r_fifo[r_rp];
    assign m0_data_tvalid = s_data_tvalid & ~w_empty & ~w_head;
    assign m1_data_tvalid = s_data_tvalid & ~w_empty & w_head;
    assign s_data_tready  = ~w_empty & (w_head ? m1_data_tready : m0_data_tready);
    assign m0_data_tdata  = s_data_tdata;
    assign m1_data_tdata  = s_data_tdata;
    assign m0_data_tkeep  = s_data_tkeep;
    assign m1_data_tkeep  = s_data_tkeep;
    assign m0_data_tlast  = s_data_tlast;
    assign m1_data_tlast  = s_data_tlast;
    assign w_pop          = s_data_tvalid & s_data_tready & s_data_tlast;

    assign w_tag         = s_sts_tdata[0];
    assign w_bad         = |s_sts_tdata[3:1];
    assign m0_sts_tvalid = s_sts_tvalid & ~w_bad & ~w_tag;
    assign m1_sts_tvalid = s_sts_tvalid & ~w_bad & w_tag;
    assign s_sts_tready  = w_bad | (w_tag ? m1_sts_tready : m0_sts_tready);
    assign m0_sts_tdata  = s_sts_tdata;
    assign m1_sts_tdata  = s_sts_tdata;
    assign w_sts_hs      = s_sts_tvalid & s_sts_tready;
    assign w_dec         = w_sts_hs & (r_out != '0);
    assign w_err_set     = w_sts_hs & (w_bad | ~s_sts_tdata[7] | (r_out == '0));
    assign w_unused      = ^s_sts_tdata[6:4];

    assign outstanding = r_out;
    assign err_sticky  = r_err;

    // FSM state, grant priority, command register, counters and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
            r_prio  <= 1'b0;
            r_cmd   <= '0;
            r_out   <= '0;
            r_err   <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_prio <= ~w_g;
                r_cmd  <= {w_cmd_sel[71:68], 3'b000, w_g, w_cmd_sel[63:0]};
            end
            r_out <= r_out + 5'(w_acc) - 5'(w_dec);
            r_err <= r_err | w_err_set;
            r_wp  <= r_wp + AW'(w_acc);
            r_rp  <= r_rp + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_acc) - (AW+1)'(w_pop);
        end
    end

    // Order FIFO storage: requester index of each accepted command
    always_ff @(posedge clk) begin
        if (w_acc) r_fifo[r_wp] <= w_g;
    end
endmodule

// File: tb/tb_dm_mm2s_arbiter.sv
// tb_dm_mm2s_arbiter: randomized episodes checked against a queue-based reference model
module tb_dm_mm2s_arbiter;
    localparam int MAX_OUT = 4;
    localparam int EP_LEN  = 300;

    logic         clk = 1'b0;
    logic         rst;
    logic         s0_cmd_tvalid, s0_cmd_tready, s1_cmd_tvalid, s1_cmd_tready;
    logic [71:0]  s0_cmd_tdata, s1_cmd_tdata, m_cmd_tdata;
    logic         m_cmd_tvalid, m_cmd_tready;
    logic         s_data_tvalid, s_data_tready, s_data_tlast;
    logic [127:0] s_data_tdata, m0_data_tdata, m1_data_tdata;
    logic [15:0]  s_data_tkeep, m0_data_tkeep, m1_data_tkeep;
    logic         m0_data_tvalid, m0_data_tready, m0_data_tlast;
    logic         m1_data_tvalid, m1_data_tready, m1_data_tlast;
    logic         s_sts_tvalid, s_sts_tready;
    logic [7:0]   s_sts_tdata, m0_sts_tdata, m1_sts_tdata;
    logic         m0_sts_tvalid, m0_sts_tready, m1_sts_tvalid, m1_sts_tready;
    logic [4:0]   outstanding;
    logic         err_sticky;

    dm_mm2s_arbiter #(.MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .s0_cmd_tvalid(s0_cmd_tvalid), .s0_cmd_tready(s0_cmd_tready), .s0_cmd_tdata(s0_cmd_tdata),
        .s1_cmd_tvalid(s1_cmd_tvalid), .s1_cmd_tready(s1_cmd_tready), .s1_cmd_tdata(s1_cmd_tdata),
        .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready), .m_cmd_tdata(m_cmd_tdata),
        .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready), .s_data_tdata(s_data_tdata),
        .s_data_tkeep(s_data_tkeep), .s_data_tlast(s_data_tlast),
        .m0_data_tvalid(m0_data_tvalid), .m0_data_tready(m0_data_tready), .m0_data_tdata(m0_data_tdata),
        .m0_data_tkeep(m0_data_tkeep), .m0_data_tlast(m0_data_tlast),
        .m1_data_tvalid(m1_data_tvalid), .m1_data_tready(m1_data_tready), .m1_data_tdata(m1_data_tdata),
        .m1_data_tkeep(m1_data_tkeep), .m1_data_tlast(m1_data_tlast),
        .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready), .s_sts_tdata(s_sts_tdata),
        .m0_sts_tvalid(m0_sts_tvalid), .m0_sts_tready(m0_sts_tready), .m0_sts_tdata(m0_sts_tdata),
        .m1_sts_tvalid(m1_sts_tvalid), .m1_sts_tready(m1_sts_tready), .m1_sts_tdata(m1_sts_tdata),
        .outstanding(outstanding), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    bit          m_send, m_fresh, m_err;
    logic [71:0] m_pend;
    int          m_prio, m_out;
    int          ord_q[$];
    int          cmp_q[$];

    // per-cycle scratch
    bit          el0, el1, acc, nq, bad, from_cmp;
    bit          e_s0r, e_s1r, e_m0dv, e_m1dv, e_sdr, e_m0sv, e_m1sv, e_ssr;
    int          g, h, t;
    logic [71:0] d;
    logic [2:0]  bad_field;

    int p_cv [8] = '{90, 60, 100, 50, 80, 100, 70, 40};
    int p_mcr[8] = '{100, 50, 20, 80, 70, 100, 30, 60};
    int p_sts[8] = '{80, 50, 5, 30, 60, 90, 40, 70};
    int p_err[8] = '{0, 0, 0, 10, 0, 5, 20, 0};

    initial begin
        rst = 1'b1;
        {s0_cmd_tvalid, s1_cmd_tvalid, m_cmd_tready, s_data_tvalid, s_data_tlast} = '0;
        {m0_data_tready, m1_data_tready, s_sts_tvalid, m0_sts_tready, m1_sts_tready} = '0;
        s0_cmd_tdata = '0; s1_cmd_tdata = '0; s_data_tdata = '0; s_data_tkeep = '0; s_sts_tdata = '0;
        for (int e = 0; e < 8; e++) begin
            for (int c = 0; c < EP_LEN; c++) begin
                @(posedge clk);
                #1;
                rst = (c == 0);
                s0_cmd_tvalid = ($urandom_range(99) < p_cv[e]);
                s1_cmd_tvalid = ($urandom_range(99) < p_cv[e]);
                s0_cmd_tdata  = {8'($urandom), 32'($urandom), 32'($urandom)};
                s1_cmd_tdata  = {8'($urandom), 32'($urandom), 32'($urandom)};
                s0_cmd_tdata[30] = 1'b1;
                s1_cmd_tdata[30] = 1'b1;
                m_cmd_tready   = ($urandom_range(99) < p_mcr[e]);
                s_data_tvalid  = ($urandom_range(99) < 70);
                s_data_tdata   = {$urandom, $urandom, $urandom, $urandom};
                s_data_tkeep   = 16'($urandom);
                s_data_tlast   = ($urandom_range(3) == 0);
                m0_data_tready = ($urandom_range(99) < 70);
                m1_data_tready = ($urandom_range(99) < 70);
                m0_sts_tready  = ($urandom_range(99) < 70);
                m1_sts_tready  = ($urandom_range(99) < 70);
                from_cmp = 0;
                s_sts_tvalid = 1'b0;
                s_sts_tdata  = 8'($urandom);
                if (cmp_q.size() > 0 && $urandom_range(99) < p_sts[e]) begin
                    from_cmp  = 1;
                    bad_field = ($urandom_range(99) < p_err[e]) ? 3'($urandom_range(7, 1)) : 3'b000;
                    s_sts_tvalid = 1'b1;
                    s_sts_tdata  = {($urandom_range(99) >= p_err[e]), 3'b000, bad_field, 1'(cmp_q[0])};
                end else if (p_err[e] > 0 && m_out == 0 && cmp_q.size() == 0 && $urandom_range(99) < 5) begin
                    s_sts_tvalid = 1'b1;
                end
                #1;
                if (c == 0) begin
                    m_send = 0; m_fresh = 1; m_err = 0; m_pend = '0; m_prio = 0; m_out = 0;
                    ord_q.delete();
                    cmp_q.delete();
                    continue;
                end
                el0 = s0_cmd_tvalid && (m_out < MAX_OUT);
                el1 = s1_cmd_tvalid && (m_out < MAX_OUT);
                acc = !m_send && (el0 || el1);
                g   = (el0 && el1) ? m_prio : (el1 ? 1 : 0);
                e_s0r = acc && g == 0;
                e_s1r = acc && g == 1;
                nq  = ord_q.size() > 0;
                h   = nq ? ord_q[0] : 0;
                e_m0dv = s_data_tvalid && nq && h == 0;
                e_m1dv = s_data_tvalid && nq && h == 1;
                e_sdr  = nq && (h == 0 ? m0_data_tready : m1_data_tready);
                t   = int'(s_sts_tdata[0]);
                bad = s_sts_tdata[3:1] != 3'b000;
                e_m0sv = s_sts_tvalid && !bad && t == 0;
                e_m1sv = s_sts_tvalid && !bad && t == 1;
                e_ssr  = bad || (t == 1 ? m1_sts_tready : m0_sts_tready);
                check("s0_cmd_tready", 128'(s0_cmd_tready), 128'(e_s0r));
                check("s1_cmd_tready", 128'(s1_cmd_tready), 128'(e_s1r));
                check("m_cmd_tvalid", 128'(m_cmd_tvalid), 128'(m_send));
                if (m_send || m_fresh) check("m_cmd_tdata", 128'(m_cmd_tdata), 128'(m_pend));
                check("m0_data_tvalid", 128'(m0_data_tvalid), 128'(e_m0dv));
                check("m1_data_tvalid", 128'(m1_data_tvalid), 128'(e_m1dv));
                check("s_data_tready", 128'(s_data_tready), 128'(e_sdr));
                check("m0_data_tdata", m0_data_tdata, s_data_tdata);
                check("m1_data_tkeep", 128'(m1_data_tkeep), 128'(s_data_tkeep));
                check("m1_data_tlast", 128'(m1_data_tlast), 128'(s_data_tlast));
                check("m0_sts_tvalid", 128'(m0_sts_tvalid), 128'(e_m0sv));
                check("m1_sts_tvalid", 128'(m1_sts_tvalid), 128'(e_m1sv));
                check("s_sts_tready", 128'(s_sts_tready), 128'(e_ssr));
                check("m1_sts_tdata", 128'(m1_sts_tdata), 128'(s_sts_tdata));
                check("outstanding", 128'(outstanding), 128'(m_out));
                check("err_sticky", 128'(err_sticky), 128'(m_err));
                if (s_sts_tvalid && e_ssr) begin
                    if (m_out == 0) m_err = 1;
                    else m_out--;
                    if (bad || !s_sts_tdata[7]) m_err = 1;
                    if (from_cmp) void'(cmp_q.pop_front());
                end
                if (s_data_tvalid && e_sdr && s_data_tlast) cmp_q.push_back(ord_q.pop_front());
                if (m_send && m_cmd_tready) m_send = 0;
                if (acc) begin
                    d = (g == 1) ? s1_cmd_tdata : s0_cmd_tdata;
                    m_pend  = {d[71:68], 4'(g), d[63:0]};
                    m_out++;
                    ord_q.push_back(g);
                    m_send  = 1;
                    m_fresh = 0;
                    m_prio  = 1 - g;
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
